// File: rtl/ps_gesture_pkg.sv
// Shared encodings for the proximity swipe detector: FSM state codes and gesture codes.
package ps_gesture_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_EVAL    = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_TRACK   = ST_TRACK,
        S_EVAL    = ST_EVAL,
        S_HOLDOFF = ST_HOLDOFF
    } gd_state_e;

    localparam logic [1:0] GEST_NONE  = 2'b00;
    localparam logic [1:0] GEST_LEFT  = 2'b01;
    localparam logic [1:0] GEST_RIGHT = 2'b10;
    localparam logic [1:0] GEST_TAP   = 2'b11;

endpackage

// File: rtl/ps_chan_track.sv
// One proximity channel: active flag with optional release hysteresis, first-crossing
// latch and timestamp. Hysteresis band enabled by defining PS_GESTURE_HYST_EN.
module ps_chan_track #(
    parameter int unsigned     DW    = 16,
    parameter logic [DW-1:0]   ON_TH = 16'd1000,
    parameter logic [DW-1:0]   HYST  = 16'd200,
    parameter int unsigned     TS_W  = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            strobe_i,
    input  logic            start_i,
    input  logic            capture_i,
    input  logic [DW-1:0]   data_i,
    input  logic [TS_W-1:0] ts_i,
    output logic            flag_nxt_o,
    output logic            rise_o,
    output logic            latched_o,
    output logic [TS_W-1:0] ts_o
);

`ifdef PS_GESTURE_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // Release threshold clamps at zero rather than wrapping when the band exceeds ON_TH.
    localparam logic [DW-1:0] REL_TH = !HYST_ON     ? ON_TH :
                                       (HYST > ON_TH) ? '0  : ON_TH - HYST;

    logic            flag_q;
    logic            flag_d;
    logic            lat_q;
    logic            lat_d;
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] ts_d;

    always_comb begin
        flag_d = flag_q;
        if (strobe_i) begin
            if (data_i >= ON_TH) begin
                flag_d = 1'b1;
            end else if (data_i < REL_TH) begin
                flag_d = 1'b0;
            end
        end
    end

    assign rise_o = strobe_i & ~flag_q & flag_d;

    // Only the first crossing inside a gesture is timestamped; re-crossings are ignored.
    always_comb begin
        lat_d = lat_q;
        ts_d  = ts_q;
        if (start_i) begin
            lat_d = rise_o;
            ts_d  = '0;
        end else if (capture_i && rise_o && !lat_q) begin
            lat_d = 1'b1;
            ts_d  = ts_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flag_q <= 1'b0;
            lat_q  <= 1'b0;
            ts_q   <= '0;
        end else begin
            flag_q <= flag_d;
            lat_q  <= lat_d;
            ts_q   <= ts_d;
        end
    end

    assign flag_nxt_o = flag_d;
    assign latched_o  = lat_q;
    assign ts_o       = ts_q;

endmodule

// File: rtl/ps_gesture_detect.sv
// Swipe classifier over three proximity channels: FSM, sample counter, classifier and
// output registers. Optional hysteresis band is enabled by defining PS_GESTURE_HYST_EN.
module ps_gesture_detect
    import ps_gesture_pkg::*;
#(
    parameter int unsigned     DW       = 16,
    parameter logic [DW-1:0]   ON_TH    = 16'd1000,
    parameter logic [DW-1:0]   HYST     = 16'd200,
    parameter int unsigned     TS_W     = 8,
    parameter logic [TS_W-1:0] TIMEOUT  = 8'd100,
    parameter logic [TS_W-1:0] HOLDOFF  = 8'd20,
    parameter logic [TS_W-1:0] MIN_SKEW = 8'd2
) (
    input  logic          CLK_50,
    input  logic          RESET_N,
    input  logic [DW-1:0] PS1_DATA,
    input  logic [DW-1:0] PS2_DATA,
    input  logic [DW-1:0] PS3_DATA,
    input  logic          PS_VALID,
    output logic [1:0]    GESTURE,
    output logic          GESTURE_VALID,
    output logic          PRESENCE,
    output logic          BUSY
);

    // PS_VALID is a one-cycle strobe with no back-pressure: a sample set is consumed on
    // every clock where it is high, and flags/counters move on no other cycle.

    gd_state_e       state_q;
    gd_state_e       state_d;
    logic [TS_W-1:0] cnt_q;
    logic [TS_W-1:0] cnt_d;
    logic [TS_W-1:0] cnt_inc;
    logic [TS_W-1:0] hold_inc;
    logic            start_trk;
    logic            capture;

    logic [DW-1:0]   ps_data [3];
    logic [2:0]      flag_nxt;
    logic [2:0]      rise;
    logic [2:0]      lat;
    logic [TS_W-1:0] ts [3];

    logic [TS_W-1:0] skew;
    logic [1:0]      code;

    logic [1:0]      res_q;
    logic            pend_q;
    logic [1:0]      gesture_q;
    logic            gv_q;
    logic            presence_q;

    assign ps_data[0] = PS1_DATA;
    assign ps_data[1] = PS2_DATA;
    assign ps_data[2] = PS3_DATA;

    for (genvar c = 0; c < 3; c++) begin : g_chan
        ps_chan_track #(
            .DW    (DW),
            .ON_TH (ON_TH),
            .HYST  (HYST),
            .TS_W  (TS_W)
        ) u_chan (
            .clk_i      (CLK_50),
            .rst_n_i    (RESET_N),
            .strobe_i   (PS_VALID),
            .start_i    (start_trk),
            .capture_i  (capture),
            .data_i     (ps_data[c]),
            .ts_i       (cnt_inc),
            .flag_nxt_o (flag_nxt[c]),
            .rise_o     (rise[c]),
            .latched_o  (lat[c]),
            .ts_o       (ts[c])
        );
    end

    assign cnt_inc  = (cnt_q >= TIMEOUT) ? TIMEOUT : cnt_q + TS_W'(1);
    assign hold_inc = (cnt_q >= HOLDOFF) ? cnt_q   : cnt_q + TS_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_trk = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (PS_VALID && (|rise)) begin
                    state_d   = S_TRACK;
                    start_trk = 1'b1;
                end
            end
            S_TRACK: begin
                if (PS_VALID) begin
                    cnt_d   = cnt_inc;
                    capture = 1'b1;
                    // All-clear takes priority over a timeout on the same strobe.
                    if (!(|flag_nxt)) begin
                        state_d = S_EVAL;
                    end else if (cnt_inc == TIMEOUT) begin
                        state_d = S_HOLDOFF;
                        cnt_d   = '0;
                    end
                end
            end
            S_EVAL: begin
                state_d = S_HOLDOFF;
                cnt_d   = '0;
            end
            S_HOLDOFF: begin
                if (PS_VALID) begin
                    cnt_d = hold_inc;
                    if ((hold_inc >= HOLDOFF) && !(|flag_nxt)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ordered unsigned subtraction keeps the skew magnitude free of sign handling.
    always_comb begin
        skew = (ts[0] >= ts[2]) ? ts[0] - ts[2] : ts[2] - ts[0];
        code = GEST_NONE;
        if (&lat) begin
            if (skew < MIN_SKEW) begin
                code = GEST_TAP;
            end else if (ts[0] < ts[2]) begin
                code = GEST_RIGHT;
            end else begin
                code = GEST_LEFT;
            end
        end
    end

    // The code is captured leaving EVAL and published one clock later together with
    // the pulse, so GESTURE never changes ahead of its GESTURE_VALID.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            res_q      <= GEST_NONE;
            pend_q     <= 1'b0;
            gesture_q  <= GEST_NONE;
            gv_q       <= 1'b0;
            presence_q <= 1'b0;
        end else begin
            pend_q     <= (state_q == S_EVAL);
            if (state_q == S_EVAL) begin
                res_q <= code;
            end
            gv_q       <= pend_q;
            if (pend_q) begin
                gesture_q <= res_q;
            end
            presence_q <= |flag_nxt;
        end
    end

    assign GESTURE       = gesture_q;
    assign GESTURE_VALID = gv_q;
    assign PRESENCE      = presence_q;
    assign BUSY          = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps_gesture_detect.sv
// Bench for ps_gesture_detect: directed spec scenarios plus randomized strobes checked
// against a per-sample behavioural model. Follows PS_GESTURE_HYST_EN like the RTL.
module tb_ps_gesture_detect;

  localparam int ON_TH    = 1000;
`ifdef PS_GESTURE_HYST_EN
  localparam int REL_TH   = 800;
  localparam int HYST_EXP = 1;
`else
  localparam int REL_TH   = 1000;
  localparam int HYST_EXP = 0;
`endif
  localparam int TIMEOUT  = 100;
  localparam int HOLDOFF  = 20;
  localparam int MIN_SKEW = 2;
  localparam int HI       = 1500;
  localparam int LO       = 100;
  localparam int NEVER    = 100000;

  localparam int M_IDLE  = 0;
  localparam int M_TRACK = 1;
  localparam int M_COOL  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] PS1_DATA = '0;
  logic [15:0] PS2_DATA = '0;
  logic [15:0] PS3_DATA = '0;
  logic        PS_VALID = 1'b0;
  logic [1:0]  GESTURE;
  logic        GESTURE_VALID;
  logic        PRESENCE;
  logic        BUSY;

  always #5 CLK_50 = ~CLK_50;

  int cyc = 0;
  always @(posedge CLK_50) cyc <= cyc + 1;

  ps_gesture_detect dut (
    .CLK_50        (CLK_50),
    .RESET_N       (RESET_N),
    .PS1_DATA      (PS1_DATA),
    .PS2_DATA      (PS2_DATA),
    .PS3_DATA      (PS3_DATA),
    .PS_VALID      (PS_VALID),
    .GESTURE       (GESTURE),
    .GESTURE_VALID (GESTURE_VALID),
    .PRESENCE      (PRESENCE),
    .BUSY          (BUSY)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];
  bit         m_flag[3];
  bit         m_lat[3];
  int         m_ts[3];
  int         m_cnt;
  int         m_mode;

  function automatic logic [1:0] ref_code();
    int d;
    int mag;
    if (!(m_lat[0] && m_lat[1] && m_lat[2])) return 2'b00;
    d   = m_ts[0] - m_ts[2];
    mag = (d < 0) ? -d : d;
    if (mag < MIN_SKEW) return 2'b11;
    return (d < 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_flag[i] = 1'b0;
      m_lat[i]  = 1'b0;
      m_ts[i]   = 0;
    end
    m_cnt  = 0;
    m_mode = M_IDLE;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic model_step(input int d1, input int d2, input int d3);
    int d[3];
    bit nf[3];
    bit rose[3];
    bit any_rose;
    bit all_clear;
    d[0] = d1; d[1] = d2; d[2] = d3;
    any_rose = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nf[i]   = (d[i] >= ON_TH) ? 1'b1 : (d[i] < REL_TH) ? 1'b0 : m_flag[i];
      rose[i] = nf[i] && !m_flag[i];
      any_rose |= rose[i];
    end
    all_clear = !(nf[0] || nf[1] || nf[2]);
    case (m_mode)
      M_IDLE: if (any_rose) begin
        m_mode = M_TRACK;
        m_cnt  = 0;
        for (int i = 0; i < 3; i++) begin
          m_lat[i] = rose[i];
          m_ts[i]  = 0;
        end
      end
      M_TRACK: begin
        m_cnt++;
        for (int i = 0; i < 3; i++)
          if (rose[i] && !m_lat[i]) begin
            m_lat[i] = 1'b1;
            m_ts[i]  = m_cnt;
          end
        if (all_clear) begin
          exp_q.push_back(ref_code());
          exp_cyc_q.push_back(cyc + 2);
          m_mode = M_COOL;
          m_cnt  = 0;
        end else if (m_cnt >= TIMEOUT) begin
          m_mode = M_COOL;
          m_cnt  = 0;
        end
      end
      default: begin
        m_cnt++;
        if (m_cnt >= HOLDOFF && all_clear) m_mode = M_IDLE;
      end
    endcase
    for (int i = 0; i < 3; i++) m_flag[i] = nf[i];
  endtask

  // ---------------- scoreboard monitor ----------------
  int n_pulses = 0;
  always @(negedge CLK_50) begin
    if (RESET_N && GESTURE_VALID) begin
      n_pulses <= n_pulses + 1;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        check("gesture", 32'(GESTURE), 32'(exp_q.pop_front()));
        check("gv_latency", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic strobe(input int d1, input int d2, input int d3);
    @(negedge CLK_50);
    PS1_DATA = 16'(d1);
    PS2_DATA = 16'(d2);
    PS3_DATA = 16'(d3);
    PS_VALID = 1'b1;
    @(negedge CLK_50);
    PS_VALID = 1'b0;
    model_step(d1, d2, d3);
    check("presence", 32'(PRESENCE), 32'(m_flag[0] || m_flag[1] || m_flag[2]));
    check("busy", 32'(BUSY), 32'(m_mode != M_IDLE));
    repeat ($urandom_range(0, 2)) @(negedge CLK_50);
  endtask

  task automatic swipe(input int t1, input int t2, input int t3, input int tclr);
    for (int s = 0; s <= tclr; s++)
      strobe((s >= t1 && s < tclr) ? HI : LO,
             (s >= t2 && s < tclr) ? HI : LO,
             (s >= t3 && s < tclr) ? HI : LO);
  endtask

  task automatic quiet(input int n);
    for (int s = 0; s < n; s++) strobe(LO, LO, LO);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int p0;
  int vals[8] = '{0, 500, 850, 950, 1000, 1001, 1500, 65535};
  int cur[3];

  initial begin
    model_reset();
    wait_cycles(3);
    check("rst_gesture", 32'(GESTURE), 32'd0);
    check("rst_gv", 32'(GESTURE_VALID), 32'd0);
    check("rst_presence", 32'(PRESENCE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    RESET_N = 1'b1;
    wait_cycles(2);

    p0 = n_pulses;
    swipe(0, 3, 6, 10);
    wait_cycles(4);
    check("right_code", 32'(GESTURE), 32'd2);
    check("right_pulses", n_pulses - p0, 1);
    quiet(HOLDOFF + 2);
    check("right_idle", 32'(BUSY), 32'd0);

    p0 = n_pulses;
    swipe(6, 3, 0, 10);
    wait_cycles(4);
    check("left_code", 32'(GESTURE), 32'd1);
    check("left_pulses", n_pulses - p0, 1);
    quiet(HOLDOFF + 2);

    swipe(0, 0, 0, 5);
    wait_cycles(4);
    check("tap_code", 32'(GESTURE), 32'd3);
    quiet(HOLDOFF + 2);

    p0 = n_pulses;
    swipe(0, NEVER, NEVER, 4);
    wait_cycles(4);
    check("none_code", 32'(GESTURE), 32'd0);
    check("none_pulses", n_pulses - p0, 1);
    quiet(HOLDOFF - 1);
    check("none_holdoff_busy", 32'(BUSY), 32'd1);
    quiet(1);
    check("none_holdoff_done", 32'(BUSY), 32'd0);

    p0 = n_pulses;
    swipe(0, 0, 0, 150);
    wait_cycles(4);
    check("held_no_pulse", n_pulses - p0, 0);
    check("held_idle", 32'(BUSY), 32'd0);

    strobe(1000, LO, LO);
    strobe(900, LO, LO);
    check("hyst_presence", 32'(PRESENCE), HYST_EXP);
    strobe(LO, LO, LO);
    quiet(HOLDOFF + 2);

    p0 = n_pulses;
    strobe(HI, LO, LO);
    strobe(HI, HI, LO);
    #2;
    RESET_N = 1'b0;
    #1;
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_presence", 32'(PRESENCE), 32'd0);
    check("midrst_gv", 32'(GESTURE_VALID), 32'd0);
    check("midrst_gesture", 32'(GESTURE), 32'd0);
    model_reset();
    @(negedge CLK_50);
    RESET_N = 1'b1;
    quiet(5);
    wait_cycles(4);
    check("midrst_no_pulse", n_pulses - p0, 0);

    for (int i = 0; i < 3; i++) cur[i] = 0;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int i = 0; i < 3; i++) cur[i] = 0;
      end else begin
        for (int i = 0; i < 3; i++)
          if ($urandom_range(0, 2) == 0) cur[i] = vals[$urandom_range(0, 7)];
      end
      strobe(cur[0], cur[1], cur[2]);
    end
    quiet(HOLDOFF + 2);
    wait_cycles(5);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
